// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the two-requester register-file arbiter.
// Holds the default parameter values, the arbiter state encoding and a
// helper that sizes the lock-hold counter.
package regfile_arb_pkg;

    localparam int unsigned ADDR_W_DEF   = 5;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned LOCK_MAX_DEF = 16;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Counter width for 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_arb_rr_arb2.sv
// Two-way round-robin pick.
// Ports:
//   valid  in  2  request valid per requester
//   ptr    in  1  requester that wins when both are valid
//   grant  out 2  one-hot grant (all zero when nobody is valid)
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_arb.sv
// Arbiter giving two requesters shared access to an external register file
// (registered reads, one-cycle latency). A requester may lock the grant for
// up to LOCK_MAX cycles; an expired lock is released and flagged on lock_err.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   req_valid/ready/lock/we      per-requester handshake and control (2 bits)
//   req_rsel1/rsel2/wsel/wdata   per-requester fields, requester i in slice i
//   rsp_valid                    one-hot, registered copy of the handshake
//   rsp_rdata1/2                 register file read data passed straight through
//   rf_*                         register file select/write interface
//   lock_err                     one-cycle pulse after a forced lock release
module regfile_arb
    import regfile_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_lock,
    input  logic [2*ADDR_W-1:0] req_rsel1,
    input  logic [2*ADDR_W-1:0] req_rsel2,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_wsel,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata1,
    output logic [DATA_W-1:0]   rsp_rdata2,
    output logic [ADDR_W-1:0]   rf_rdsel1,
    output logic [ADDR_W-1:0]   rf_rdsel2,
    output logic [ADDR_W-1:0]   rf_wtsel,
    output logic [DATA_W-1:0]   rf_wtdata,
    output logic                rf_wenable,
    input  logic [DATA_W-1:0]   rf_rdata1,
    input  logic [DATA_W-1:0]   rf_rdata2,
    output logic                lock_err
);

    localparam int unsigned CNT_W = cnt_width(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_e       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [1:0]       rsp_valid_q;
    logic             lock_err_q, lock_err_d;

    logic [1:0]       arb_grant;
    logic [1:0]       ready;
    logic [1:0]       hs;
    logic             sel;

    logic [ADDR_W-1:0] rsel1_a [2];
    logic [ADDR_W-1:0] rsel2_a [2];
    logic [ADDR_W-1:0] wsel_a  [2];
    logic [DATA_W-1:0] wdata_a [2];

    for (genvar i = 0; i < 2; i++) begin : g_unpack
        assign rsel1_a[i] = req_rsel1[i*ADDR_W +: ADDR_W];
        assign rsel2_a[i] = req_rsel2[i*ADDR_W +: ADDR_W];
        assign wsel_a[i]  = req_wsel[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    rr_arb2 u_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant)
    );

    // Ready is combinational, so it is also gated by rst to stay low in reset.
    always_comb begin
        ready = 2'b00;
        if (rst) begin
            if (state_q == ARB) begin
                ready = arb_grant;
            end else begin
                ready[owner_q] = req_valid[owner_q];
            end
        end
    end

    assign req_ready = ready;
    assign hs        = req_valid & ready;
    // ready is one-hot or zero, so bit 1 names the granted requester.
    assign sel       = ready[1];

    always_comb begin
        rf_rdsel1  = '0;
        rf_rdsel2  = '0;
        rf_wtsel   = '0;
        rf_wtdata  = '0;
        rf_wenable = 1'b0;
        if (|ready) begin
            rf_rdsel1  = rsel1_a[sel];
            rf_rdsel2  = rsel2_a[sel];
            rf_wtsel   = wsel_a[sel];
            rf_wtdata  = wdata_a[sel];
            rf_wenable = (|hs) & req_we[sel];
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        lock_err_d = 1'b0;
        case (state_q)
            ARB: begin
                if (|hs) begin
                    if (req_lock[sel]) begin
                        state_d    = LOCKED;
                        owner_d    = sel;
                        lock_cnt_d = '0;
                    end else begin
                        ptr_d = ~sel;
                    end
                end
            end
            LOCKED: begin
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
                // A releasing handshake wins over a coinciding timeout.
                if (hs[owner_q] && !req_lock[owner_q]) begin
                    state_d = ARB;
                    ptr_d   = ~owner_q;
                end else if (lock_cnt_q == CNT_LAST) begin
                    state_d    = ARB;
                    ptr_d      = ~owner_q;
                    lock_err_d = 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            lock_cnt_q  <= '0;
            rsp_valid_q <= 2'b00;
            lock_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_valid_q <= hs;
            lock_err_q  <= lock_err_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign lock_err   = lock_err_q;
    assign rsp_rdata1 = rf_rdata1;
    assign rsp_rdata2 = rf_rdata2;

endmodule
